// File: rtl/axi2mem_pkg.sv
// Shared definitions for the axi2mem read/write burst generators.
package axi2mem_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned SIZE_W     = 3;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned SIZE_CLAMP = 3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [SIZE_W-1:0] DWORD_SIZE = SIZE_W'(3);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    // Word address of a beat; 64-bit beats select the low or high word by phase.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [SIZE_W-1:0] size,
                                                    input logic              phase);
        logic [ADDR_W-1:0] w;
        w = a & ~ADDR_W'(WORD_BYTES - 1);
        if (size == DWORD_SIZE) begin
            w = {a[ADDR_W-1:3], 3'b000} | (phase ? ADDR_W'(WORD_BYTES) : ADDR_W'(0));
        end
        return w;
    endfunction

endpackage

// File: rtl/axi2mem_rd_burst_gen_if.sv
// AR command and word-transaction bus of the read burst generator.
interface axi2mem_rd_burst_gen_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 6
);
    logic              ar_valid_i;
    logic              ar_ready_o;
    logic [ADDR_W-1:0] ar_addr_i;
    logic [7:0]        ar_len_i;
    logic [2:0]        ar_size_i;
    logic [1:0]        ar_burst_i;
    logic [ID_W-1:0]   ar_id_i;
    logic              trans_req_o;
    logic              trans_gnt_i;
    logic [31:0]       trans_add_o;
    logic [ID_W-1:0]   trans_id_o;
    logic              trans_last_o;

    modport slave (
        input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i, trans_gnt_i,
        output ar_ready_o, trans_req_o, trans_add_o, trans_id_o, trans_last_o
    );

    modport master (
        output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i, trans_gnt_i,
        input  ar_ready_o, trans_req_o, trans_add_o, trans_id_o, trans_last_o
    );
endinterface

// File: rtl/axi2mem_addr_next.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by read and write sides.
module axi2mem_addr_next
    import axi2mem_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_addr_next_c
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_al;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;
    logic              w_wrap_ok;

    assign w_step = ADDR_W'(1) << i_size;
    assign w_al   = i_addr & ~(w_step - ADDR_W'(1));
    assign w_inc  = w_al + w_step;
    assign w_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);

    // Only power-of-two beat counts of 2..16 are legal wrap lengths.
    assign w_wrap_ok = (i_len == LEN_W'(1)) || (i_len == LEN_W'(3)) ||
                       (i_len == LEN_W'(7)) || (i_len == LEN_W'(15));

    always_comb begin
        o_addr_next_c = w_inc;
        unique case (i_burst)
            BURST_FIXED: o_addr_next_c = i_addr;
            BURST_WRAP: begin
                if (w_wrap_ok) begin
                    o_addr_next_c = (w_al & ~w_mask) | (w_inc & w_mask);
                end
            end
            default:     o_addr_next_c = w_inc;
        endcase
    end

endmodule

// File: rtl/axi2mem_rd_burst_gen.sv
// Expands one AXI AR burst into a stream of 32-bit word requests with req/gnt handshake.
// Optional macro AXI2MEM_RD_BACK2BACK_EN: accept the next AR during the final grant (no bubble).
module axi2mem_rd_burst_gen
    import axi2mem_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned MAX_SIZE       = SIZE_CLAMP
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    axi2mem_rd_burst_gen_if.slave  bus,
    output logic                   busy_o
);

    rd_state_e                 r_state,  w_state_n;
    logic [AXI_ADDR_WIDTH-1:0] r_addr,   w_addr_n;
    logic [LEN_W-1:0]          r_len,    w_len_n;
    logic [SIZE_W-1:0]         r_size,   w_size_n;
    logic [1:0]                r_burst,  w_burst_n;
    logic [AXI_ID_WIDTH-1:0]   r_id,     w_id_n;
    logic [LEN_W-1:0]          r_cnt,    w_cnt_n;
    logic                      r_phase,  w_phase_n;

    logic                      r_req;
    logic [31:0]               r_add;
    logic                      r_last;
    logic                      r_busy;
    logic                      r_ar_ready;

    logic                      w_accept;
    logic                      w_last_gnt;
    logic [SIZE_W-1:0]         w_size_clamped;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_next;

    assign w_size_clamped = (bus.ar_size_i > SIZE_W'(MAX_SIZE)) ? SIZE_W'(MAX_SIZE)
                                                                : bus.ar_size_i;

    axi2mem_addr_next u_addr_next (
        .i_addr        (r_addr),
        .i_len         (r_len),
        .i_size        (r_size),
        .i_burst       (r_burst),
        .o_addr_next_c (w_addr_next)
    );

    // Next-state: accept a command, step word phase / beat on each grant.
    always_comb begin
        w_state_n  = r_state;
        w_addr_n   = r_addr;
        w_len_n    = r_len;
        w_size_n   = r_size;
        w_burst_n  = r_burst;
        w_id_n     = r_id;
        w_cnt_n    = r_cnt;
        w_phase_n  = r_phase;
        w_accept   = 1'b0;
        w_last_gnt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_accept = bus.ar_valid_i;
            end
            ST_BURST: begin
                if (bus.trans_gnt_i) begin
                    if (r_last) begin
                        w_last_gnt = 1'b1;
                    end else if ((r_size == DWORD_SIZE) && !r_phase) begin
                        w_phase_n = 1'b1;
                    end else begin
                        w_phase_n = 1'b0;
                        w_cnt_n   = r_cnt - LEN_W'(1);
                        w_addr_n  = w_addr_next;
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (w_last_gnt) begin
            w_state_n = ST_IDLE;
        end

`ifdef AXI2MEM_RD_BACK2BACK_EN
        if (w_last_gnt && bus.ar_valid_i) begin
            w_accept = 1'b1;
        end
`endif

        if (w_accept) begin
            w_state_n = ST_BURST;
            w_addr_n  = bus.ar_addr_i;
            w_len_n   = bus.ar_len_i;
            w_size_n  = w_size_clamped;
            w_burst_n = bus.ar_burst_i;
            w_id_n    = bus.ar_id_i;
            w_cnt_n   = bus.ar_len_i;
            w_phase_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_id       <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_req      <= 1'b0;
            r_add      <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_ar_ready <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_addr     <= w_addr_n;
            r_len      <= w_len_n;
            r_size     <= w_size_n;
            r_burst    <= w_burst_n;
            r_id       <= w_id_n;
            r_cnt      <= w_cnt_n;
            r_phase    <= w_phase_n;
            r_req      <= (w_state_n == ST_BURST);
            r_add      <= word_addr(32'(w_addr_n), w_size_n, w_phase_n);
            r_last     <= (w_state_n == ST_BURST) && (w_cnt_n == '0) &&
                          ((w_size_n != DWORD_SIZE) || w_phase_n);
            r_busy     <= (w_state_n == ST_BURST);
            r_ar_ready <= (w_state_n == ST_IDLE);
        end
    end

`ifdef AXI2MEM_RD_BACK2BACK_EN
    assign bus.ar_ready_o = r_ar_ready | w_last_gnt;
`else
    assign bus.ar_ready_o = r_ar_ready;
`endif

    assign bus.trans_req_o  = r_req;
    assign bus.trans_add_o  = r_add;
    assign bus.trans_id_o   = r_id;
    assign bus.trans_last_o = r_last;
    assign busy_o           = r_busy;

endmodule

// File: doc/axi2mem_rd_burst_gen.md
Name: axi2mem_rd_burst_gen

Overview:
- Read-command stage directly upstream of the TCDM read interface.
- Accepts one AXI read address (AR) command at a time.
- Expands the burst into a sequence of single 32-bit word transactions (`trans_add`/`trans_id`/`trans_last`) with a req/gnt handshake.
- Handles FIXED, INCR and WRAP bursts, and splits 64-bit beats into two word accesses.

Parameters:
- AXI_ADDR_WIDTH, 32, AR address width; must be 32 (matches `trans_add_o`).
- AXI_ID_WIDTH, 6, AR/transaction ID width.
- MAX_SIZE, 3, largest supported `ar_size` (log2 bytes); larger sizes clamp to MAX_SIZE.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ar_valid_i  in  1  AR command valid
- ar_ready_o  out  1  AR command accepted
- ar_addr_i  in  32  burst start byte address
- ar_len_i  in  8  beats minus one
- ar_size_i  in  3  log2 bytes per beat
- ar_burst_i  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
- ar_id_i  in  6  transaction ID
- trans_req_o  out  1  word transaction request
- trans_gnt_i  in  1  word transaction granted
- trans_add_o  out  32  word address, bits [1:0] always 0
- trans_id_o  out  6  ID of current burst
- trans_last_o  out  1  final word of burst
- busy_o  out  1  a burst is in progress

Behaviour:
- Reset values: `ar_ready_o`=1 (IDLE), `trans_req_o`=0, `trans_add_o`=0, `trans_id_o`=0, `trans_last_o`=0, `busy_o`=0.
- Reset asserted mid-burst aborts the burst; outputs take reset values asynchronously. No partial-burst recovery.
- FSM states: IDLE and BURST.
- IDLE:
  - `ar_ready_o`=1, `trans_req_o`=0.
  - On `ar_valid_i` in IDLE, latch addr/len/size/burst/id; beat counter = len; word phase = 0; go to BURST.
  - First `trans_req_o` is asserted in the next cycle (one-cycle AR-to-request latency).
- BURST:
  - `ar_ready_o`=0 (see Optional Feature), `trans_req_o`=1, `busy_o`=1.
  - `trans_add_o`, `trans_id_o` and `trans_last_o` are registered and held stable until `trans_gnt_i`.
- Advance on grant:
  - Each cycle with `trans_req_o` and `trans_gnt_i` advances exactly one word.
  - Without a grant, nothing changes; `trans_req_o` is never dropped while pending.
- Size handling:
  - Size ≤ 2: one word per beat; `trans_add_o` = beat address with [1:0] cleared.
  - Sub-word lane selection belongs to the downstream packer.
  - Size 3: two words per beat, low word (addr[2]=0) first, then high word (addr[2]=1).
  - An unaligned size-3 start still issues both words of the aligned dword.
- `trans_last_o` = (beat counter == 0) and (size < 3 or word phase == 1).
- On the grant of the last word, return to IDLE.
- Next beat address; A_al = addr aligned down to 2^size, step = 2^size:
  - FIXED: the address never changes.
  - INCR: next = A_al + step, 32-bit wrap-around, no 4 KB check. Reserved burst type 3 is treated as INCR.
  - WRAP: mask = ((len+1) << size) − 1; next = (A_al & ~mask) | ((A_al + step) & mask).
  - WRAP with len ∉ {1,3,7,15} is treated as INCR.
- Counter width: the beat counter is 8 bits, so a 256-beat burst (len=255) is supported, giving 512 words at size 3.
- Simultaneous events: `ar_valid_i` during BURST is ignored (not accepted) unless the Optional Feature is enabled.

Optional Feature:
- Macro: AXI2MEM_RD_BACK2BACK_EN.
- Defined:
  - During the cycle in which the last word is granted, `ar_ready_o`=1.
  - If `ar_valid_i` is also high, the new command is latched and the FSM stays in BURST.
  - The first request of the new burst appears in the next cycle, with zero bubble between bursts.
- Undefined: the FSM always passes through IDLE, giving one idle cycle between bursts.

Decomposition:
- Shared package `axi2mem_pkg` holds:
  - burst-type constants (BURST_FIXED/INCR/WRAP),
  - the rd_burst_gen state enum,
  - WORD_BYTES = 4,
  - the size-clamp constant.
- Sub-module `axi2mem_addr_next`: purely combinational next-beat address from addr/len/size/burst. It is reused by the write-side burst generator.

Test Plan:
- INCR: addr 0x1000, len 3, size 2, id 5, `trans_gnt_i` always 1 → 4 requests at 0x1000, 0x1004, 0x1008, 0x100C, all with id 5; `trans_last_o` only on 0x100C; `ar_ready_o` high again the next cycle.
- WRAP: addr 0x2008, len 3, size 2 → addresses 0x2008, 0x200C, 0x2000, 0x2004; last on 0x2004.
- Size 3 INCR: addr 0x3000, len 1 → words 0x3000, 0x3004, 0x3008, 0x300C; last only on 0x300C.
- FIXED with stalls: addr 0x4010, len 2, gnt toggling 0/1 → three requests, all 0x4010; outputs stable while gnt=0; no word skipped or duplicated.
- Reset mid-burst: assert `rst_ni`=0 after 2 of 8 grants → `trans_req_o` drops immediately; after release, `ar_ready_o`=1 and a new INCR burst starts correctly.
- Back-to-back: with AXI2MEM_RD_BACK2BACK_EN defined, present a second AR during the final grant → the second burst's first request appears in the next cycle. Without the macro → exactly one idle cycle between bursts.
